// File: rtl/axis_bram_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : axis_bram_pkg
//  Purpose  : Shared types and constants for the ping-pong BRAM write
//             controller: the write-side state encoding, default geometry of
//             one bank, and the dropped-word counter step.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package axis_bram_pkg;

    // Write-side sequencing: FILL writes incoming words, STALL waits for the
    // reader to free the bank we toggled into.
    typedef enum logic [0:0] {
        FILL  = 1'b0,
        STALL = 1'b1
    } state_e;

    // Default bank geometry: words per bank and width of a length field that
    // must be able to hold the value DEPTH itself.
    localparam int unsigned BUF_ADDR_WIDTH_DEF = 10;
    localparam int unsigned BUF_DEPTH_DEF      = 1 << BUF_ADDR_WIDTH_DEF;
    localparam int unsigned BUF_LEN_WIDTH_DEF  = BUF_ADDR_WIDTH_DEF + 1;

    // Step applied to the dropped-word counter while it is below all-ones.
    localparam int unsigned OVF_SAT_STEP = 1;

endpackage : axis_bram_pkg
`default_nettype wire

// File: rtl/axis_bram_bank_tracker.sv
`default_nettype none
// ============================================================================
//  Module   : axis_bram_bank_tracker
//  Purpose  : Full flag and stored length for one BRAM bank. Set on close,
//             cleared one cycle after a release of a full bank. A close in
//             the same cycle as a release wins.
//  Ports    : clk_i, rst_i      clock / synchronous active-high reset
//             close_i           bank is closed this cycle
//             close_len_i       number of words in the closing bank
//             release_i         reader frees this bank (one-cycle pulse)
//             full_o, len_o     registered status
//  Revision : 1.0  initial release
// ============================================================================
module axis_bram_bank_tracker
    import axis_bram_pkg::*;
#(
    parameter int LEN_WIDTH = BUF_LEN_WIDTH_DEF
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 close_i,
    input  logic [LEN_WIDTH-1:0] close_len_i,
    input  logic                 release_i,
    output logic                 full_o,
    output logic [LEN_WIDTH-1:0] len_o
);

    logic                 full_q, full_d;
    logic [LEN_WIDTH-1:0] len_q,  len_d;

    always_comb begin
        full_d = full_q;
        len_d  = len_q;
        if (close_i) begin
            full_d = 1'b1;
            len_d  = close_len_i;
        end else if (release_i && full_q) begin
            // Releasing an empty bank is meaningless and is ignored.
            full_d = 1'b0;
            len_d  = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            full_q <= 1'b0;
            len_q  <= '0;
        end else begin
            full_q <= full_d;
            len_q  <= len_d;
        end
    end

    assign full_o = full_q;
    assign len_o  = len_q;

endmodule : axis_bram_bank_tracker
`default_nettype wire

// File: rtl/axis_bram_pingpong_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : axis_bram_pingpong_ctrl
//  Purpose  : Write-side controller that steers the AXIS-to-BRAM adapter word
//             stream into a dual-bank (ping-pong) BRAM. Closes a bank on LAST
//             or when it is full, stalls when the next bank is still owned by
//             the reader, keeps one in-flight word in a skid register and
//             counts any word beyond that as dropped.
//  Ports    : S_AXIS_ACLK / S_AXIS_ARESET   clock, sync active-high reset
//             DIN, DIN_VALID, DIN_LAST       word stream from adapter
//             DIN_ACCEP                      registered accept to adapter
//             BRAM_EN/WE/ADDR/DIN            BRAM write port
//             ACTIVE_BANK, BUF_FULL,
//             BUF_LEN0, BUF_LEN1             bank status
//             BUF_RELEASE                    per-bank release from reader
//             OVERFLOW, OVF_CNT              sticky drop flag, drop count
//  Revision : 1.0  initial release
// ============================================================================
module axis_bram_pingpong_ctrl
    import axis_bram_pkg::*;
#(
    parameter int C_S_AXIS_TDATA_WIDTH = 32,
    parameter int C_BUF_ADDR_WIDTH     = BUF_ADDR_WIDTH_DEF,
    parameter int C_OVF_CNT_WIDTH      = 16
) (
    input  logic                            S_AXIS_ACLK,
    input  logic                            S_AXIS_ARESET,
    input  logic [C_S_AXIS_TDATA_WIDTH-1:0] DIN,
    input  logic                            DIN_VALID,
    input  logic                            DIN_LAST,
    output logic                            DIN_ACCEP,
    output logic                            BRAM_EN,
    output logic                            BRAM_WE,
    output logic [C_BUF_ADDR_WIDTH:0]       BRAM_ADDR,
    output logic [C_S_AXIS_TDATA_WIDTH-1:0] BRAM_DIN,
    output logic                            ACTIVE_BANK,
    output logic [1:0]                      BUF_FULL,
    output logic [C_BUF_ADDR_WIDTH:0]       BUF_LEN0,
    output logic [C_BUF_ADDR_WIDTH:0]       BUF_LEN1,
    input  logic [1:0]                      BUF_RELEASE,
    output logic                            OVERFLOW,
    output logic [C_OVF_CNT_WIDTH-1:0]      OVF_CNT
);

    localparam int AW    = C_BUF_ADDR_WIDTH;
    localparam int DW    = C_S_AXIS_TDATA_WIDTH;
    localparam int LEN_W = C_BUF_ADDR_WIDTH + 1;
    localparam int DEPTH = 1 << C_BUF_ADDR_WIDTH;
    localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

    // ---------------------------------------------------------------- state
    state_e                 state_q, state_d;
    logic                   active_q, active_d;
    logic [AW-1:0]          ptr_q, ptr_d;
    logic                   skid_valid_q, skid_valid_d;
    logic [DW-1:0]          skid_data_q, skid_data_d;
    logic                   skid_last_q, skid_last_d;
    logic                   din_accep_q, din_accep_d;
    logic                   bram_en_q, bram_en_d;
    logic [AW:0]            bram_addr_q, bram_addr_d;
    logic [DW-1:0]          bram_din_q, bram_din_d;
    logic                   overflow_q, overflow_d;
    logic [C_OVF_CNT_WIDTH-1:0] ovf_cnt_q, ovf_cnt_d;

    // ------------------------------------------------------------- combos
    logic                   wr_valid;
    logic [DW-1:0]          wr_data;
    logic                   wr_last;
    logic                   drop;
    logic [1:0]             bank_close;
    logic [LEN_W-1:0]       close_len;
    logic                   other_bank;
    logic                   other_full_eff;
    logic                   active_full_eff;
    logic                   active_released;
    logic                   next_bank_full;

    logic [1:0]             buf_full;
    logic [LEN_W-1:0]       bank_len [2];

    always_comb begin
        state_d      = state_q;
        active_d     = active_q;
        ptr_d        = ptr_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_last_d  = skid_last_q;
        bram_en_d    = 1'b0;
        bram_addr_d  = bram_addr_q;
        bram_din_d   = bram_din_q;
        overflow_d   = overflow_q;
        ovf_cnt_d    = ovf_cnt_q;
        wr_valid     = 1'b0;
        wr_data      = DIN;
        wr_last      = DIN_LAST;
        drop         = 1'b0;
        bank_close   = 2'b00;
        close_len    = LEN_W'(ptr_q) + LEN_W'(1);

        other_bank      = ~active_q;
        // A bank counts as occupied for next cycle only if no release hits it.
        other_full_eff  = buf_full[other_bank] & ~BUF_RELEASE[other_bank];
        active_full_eff = buf_full[active_q]   & ~BUF_RELEASE[active_q];
        active_released = buf_full[active_q]   &  BUF_RELEASE[active_q];

        case (state_q)
            FILL: begin
                if (DIN_VALID) begin
                    wr_valid = 1'b1;
                end
            end
            STALL: begin
                if (active_released) begin
                    // Bank freed: flush the skid to ptr 0. Incoming data is
                    // only written directly when the skid has nothing queued.
                    state_d = FILL;
                    if (skid_valid_q) begin
                        wr_valid     = 1'b1;
                        wr_data      = skid_data_q;
                        wr_last      = skid_last_q;
                        skid_valid_d = 1'b0;
                        drop         = DIN_VALID;
                    end else if (DIN_VALID) begin
                        wr_valid = 1'b1;
                    end
                end else if (DIN_VALID) begin
                    if (!skid_valid_q) begin
                        skid_valid_d = 1'b1;
                        skid_data_d  = DIN;
                        skid_last_d  = DIN_LAST;
                    end else begin
                        drop = 1'b1;
                    end
                end
            end
            default: state_d = FILL;
        endcase

        if (wr_valid) begin
            bram_en_d   = 1'b1;
            bram_addr_d = {active_q, ptr_q};
            bram_din_d  = wr_data;
            if (wr_last || (ptr_q == PTR_LAST)) begin
                bank_close[active_q] = 1'b1;
                active_d             = other_bank;
                ptr_d                = '0;
                if (other_full_eff) begin
                    state_d = STALL;
                end
            end else begin
                ptr_d = ptr_q + AW'(1);
            end
        end

        if (drop) begin
            overflow_d = 1'b1;
            if (ovf_cnt_q != '1) begin
                ovf_cnt_d = ovf_cnt_q + C_OVF_CNT_WIDTH'(OVF_SAT_STEP);
            end
        end

        // The bank we will be filling next cycle, as seen after this cycle's
        // close/release activity.
        next_bank_full = (active_d != active_q) ? other_full_eff : active_full_eff;
        din_accep_d    = ~next_bank_full & (state_d == FILL);
    end

    always_ff @(posedge S_AXIS_ACLK) begin
        if (S_AXIS_ARESET) begin
            state_q      <= FILL;
            active_q     <= 1'b0;
            ptr_q        <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_last_q  <= 1'b0;
            din_accep_q  <= 1'b0;
            bram_en_q    <= 1'b0;
            bram_addr_q  <= '0;
            bram_din_q   <= '0;
            overflow_q   <= 1'b0;
            ovf_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            active_q     <= active_d;
            ptr_q        <= ptr_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_last_q  <= skid_last_d;
            din_accep_q  <= din_accep_d;
            bram_en_q    <= bram_en_d;
            bram_addr_q  <= bram_addr_d;
            bram_din_q   <= bram_din_d;
            overflow_q   <= overflow_d;
            ovf_cnt_q    <= ovf_cnt_d;
        end
    end

    // ----------------------------------------------------- bank trackers
    for (genvar b = 0; b < 2; b++) begin : g_bank
        axis_bram_bank_tracker #(
            .LEN_WIDTH (LEN_W)
        ) u_tracker (
            .clk_i       (S_AXIS_ACLK),
            .rst_i       (S_AXIS_ARESET),
            .close_i     (bank_close[b]),
            .close_len_i (close_len),
            .release_i   (BUF_RELEASE[b]),
            .full_o      (buf_full[b]),
            .len_o       (bank_len[b])
        );
    end

    // ------------------------------------------------------------ outputs
    assign DIN_ACCEP   = din_accep_q;
    assign BRAM_EN     = bram_en_q;
    assign BRAM_WE     = bram_en_q;
    assign BRAM_ADDR   = bram_addr_q;
    assign BRAM_DIN    = bram_din_q;
    assign ACTIVE_BANK = active_q;
    assign BUF_FULL    = buf_full;
    assign BUF_LEN0    = bank_len[0];
    assign BUF_LEN1    = bank_len[1];
    assign OVERFLOW    = overflow_q;
    assign OVF_CNT     = ovf_cnt_q;

endmodule : axis_bram_pingpong_ctrl
`default_nettype wire

// File: tb/tb_axis_bram_pingpong_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axis_bram_pingpong_ctrl
//  Purpose  : Directed self-checking bench for axis_bram_pingpong_ctrl with
//             16-word banks and a 2-bit dropped-word counter.
//  Revision : 1.0  initial release
// ============================================================================
module tb_axis_bram_pingpong_ctrl;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam int OW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] din = '0;
    logic          din_valid = 1'b0;
    logic          din_last = 1'b0;
    logic          din_accep;
    logic          bram_en;
    logic          bram_we;
    logic [AW:0]   bram_addr;
    logic [DW-1:0] bram_din;
    logic          active_bank;
    logic [1:0]    buf_full;
    logic [AW:0]   buf_len0;
    logic [AW:0]   buf_len1;
    logic [1:0]    buf_release = 2'b00;
    logic          overflow;
    logic [OW-1:0] ovf_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    axis_bram_pingpong_ctrl #(
        .C_S_AXIS_TDATA_WIDTH (DW),
        .C_BUF_ADDR_WIDTH     (AW),
        .C_OVF_CNT_WIDTH      (OW)
    ) dut (
        .S_AXIS_ACLK   (clk),
        .S_AXIS_ARESET (rst),
        .DIN           (din),
        .DIN_VALID     (din_valid),
        .DIN_LAST      (din_last),
        .DIN_ACCEP     (din_accep),
        .BRAM_EN       (bram_en),
        .BRAM_WE       (bram_we),
        .BRAM_ADDR     (bram_addr),
        .BRAM_DIN      (bram_din),
        .ACTIVE_BANK   (active_bank),
        .BUF_FULL      (buf_full),
        .BUF_LEN0      (buf_len0),
        .BUF_LEN1      (buf_len1),
        .BUF_RELEASE   (buf_release),
        .OVERFLOW      (overflow),
        .OVF_CNT       (ovf_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle past the edge before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input logic l);
        din       = d;
        din_valid = 1'b1;
        din_last  = l;
        step();
        din_valid = 1'b0;
        din_last  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    // Two 3-word frames with no release: both banks full, back in bank 0.
    task automatic fill_both();
        send(32'h31, 1'b0);
        send(32'h32, 1'b0);
        send(32'h33, 1'b1);
        send(32'h34, 1'b0);
        send(32'h35, 1'b0);
        send(32'h36, 1'b1);
    endtask

    initial begin
        // ---------------- reset state
        step();
        step();
        check("rst_accep", 32'(din_accep), 32'd0);
        check("rst_en", 32'(bram_en), 32'd0);
        check("rst_full", 32'(buf_full), 32'd0);
        check("rst_ovf", 32'(ovf_cnt), 32'd0);
        rst = 1'b0;
        step();
        check("post_rst_accep", 32'(din_accep), 32'd1);
        check("post_rst_en", 32'(bram_en), 32'd0);

        // ---------------- 5-word frame into bank 0
        for (int i = 0; i < 5; i++) begin
            send(32'hA0 + 32'(i), (i == 4));
            check("f5_en", 32'(bram_en), 32'd1);
            check("f5_we", 32'(bram_we), 32'd1);
            check("f5_addr", 32'(bram_addr), 32'(i));
            check("f5_din", bram_din, 32'hA0 + 32'(i));
        end
        check("f5_full", 32'(buf_full), 32'b01);
        check("f5_len0", 32'(buf_len0), 32'd5);
        check("f5_active", 32'(active_bank), 32'd1);
        check("f5_accep", 32'(din_accep), 32'd1);
        buf_release = 2'b01;
        step();
        buf_release = 2'b00;
        check("f5_rel_full", 32'(buf_full), 32'b00);
        check("f5_rel_len0", 32'(buf_len0), 32'd0);

        // ---------------- 20 words, no LAST: full-depth close
        do_reset();
        for (int i = 0; i < 20; i++) begin
            send(32'h100 + 32'(i), 1'b0);
            check("d20_addr", 32'(bram_addr), 32'(i));
            if (i == 15) begin
                check("d20_full", 32'(buf_full), 32'b01);
                check("d20_len0", 32'(buf_len0), 32'd16);
                check("d20_active", 32'(active_bank), 32'd1);
            end
        end
        check("d20_din", bram_din, 32'h113);
        check("d20_accep", 32'(din_accep), 32'd1);

        // ---------------- both full, one word into skid, release bank 0
        do_reset();
        fill_both();
        check("st_accep", 32'(din_accep), 32'd0);
        check("st_full", 32'(buf_full), 32'b11);
        check("st_len1", 32'(buf_len1), 32'd3);
        check("st_active", 32'(active_bank), 32'd0);
        send(32'h77, 1'b0);
        check("st_skid_en", 32'(bram_en), 32'd0);
        check("st_skid_ovf", 32'(overflow), 32'd0);
        step();
        buf_release = 2'b01;
        step();
        buf_release = 2'b00;
        check("st_flush_en", 32'(bram_en), 32'd1);
        check("st_flush_addr", 32'(bram_addr), 32'd0);
        check("st_flush_din", bram_din, 32'h77);
        check("st_flush_accep", 32'(din_accep), 32'd1);
        check("st_flush_full", 32'(buf_full), 32'b10);
        check("st_flush_len0", 32'(buf_len0), 32'd0);
        step();
        check("st_idle_en", 32'(bram_en), 32'd0);
        check("st_hold_addr", 32'(bram_addr), 32'd0);
        check("st_hold_din", bram_din, 32'h77);

        // ---------------- drops in STALL, counter saturation
        do_reset();
        fill_both();
        send(32'h81, 1'b0);
        send(32'h82, 1'b0);
        check("ov_flag", 32'(overflow), 32'd1);
        check("ov_cnt1", 32'(ovf_cnt), 32'd1);
        send(32'h83, 1'b0);
        send(32'h84, 1'b0);
        check("ov_cnt3", 32'(ovf_cnt), 32'd3);
        send(32'h85, 1'b0);
        check("ov_sat", 32'(ovf_cnt), 32'd3);
        buf_release = 2'b01;
        step();
        buf_release = 2'b00;
        check("ov_flush_din", bram_din, 32'h81);
        check("ov_flush_addr", 32'(bram_addr), 32'd0);
        check("ov_accep", 32'(din_accep), 32'd1);
        send(32'h90, 1'b0);
        check("ov_next_addr", 32'(bram_addr), 32'd1);
        check("ov_sticky", 32'(overflow), 32'd1);

        // ---------------- release / close races
        do_reset();
        send(32'h51, 1'b0);
        send(32'h52, 1'b1);
        buf_release = 2'b01;
        step();
        buf_release = 2'b00;
        check("rc_clear", 32'(buf_full), 32'b00);
        send(32'h53, 1'b0);
        send(32'h54, 1'b1);
        check("rc_len1", 32'(buf_len1), 32'd2);
        check("rc_b1_full", 32'(buf_full), 32'b10);
        send(32'h55, 1'b0);
        buf_release = 2'b10;
        send(32'h56, 1'b1);
        buf_release = 2'b00;
        check("rc_other_accep", 32'(din_accep), 32'd1);
        check("rc_other_full", 32'(buf_full), 32'b01);
        check("rc_other_len0", 32'(buf_len0), 32'd2);
        check("rc_other_len1", 32'(buf_len1), 32'd0);
        check("rc_other_active", 32'(active_bank), 32'd1);
        buf_release = 2'b01;
        step();
        buf_release = 2'b00;
        send(32'h57, 1'b1);
        check("rc_b1_addr", 32'(bram_addr), 32'd16);
        buf_release = 2'b01;
        send(32'h58, 1'b1);
        buf_release = 2'b00;
        check("rc_same_full", 32'(buf_full), 32'b11);
        check("rc_same_len0", 32'(buf_len0), 32'd1);
        check("rc_same_accep", 32'(din_accep), 32'd0);
        buf_release = 2'b11;
        step();
        buf_release = 2'b00;
        check("rc_both_full", 32'(buf_full), 32'b00);
        check("rc_both_accep", 32'(din_accep), 32'd1);

        // ---------------- reset mid-frame (bank 1, 3 words in)
        send(32'h61, 1'b0);
        send(32'h62, 1'b0);
        send(32'h63, 1'b0);
        check("mr_addr", 32'(bram_addr), 32'd18);
        rst = 1'b1;
        step();
        check("mr_active", 32'(active_bank), 32'd0);
        check("mr_full", 32'(buf_full), 32'b00);
        check("mr_len0", 32'(buf_len0), 32'd0);
        check("mr_accep", 32'(din_accep), 32'd0);
        check("mr_en", 32'(bram_en), 32'd0);
        check("mr_bram_addr", 32'(bram_addr), 32'd0);
        check("mr_ovf", 32'(overflow), 32'd0);
        rst = 1'b0;
        step();
        check("mr_accep_up", 32'(din_accep), 32'd1);
        send(32'h71, 1'b0);
        check("mr_restart_addr", 32'(bram_addr), 32'd0);
        check("mr_restart_din", bram_din, 32'h71);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_axis_bram_pingpong_ctrl
`default_nettype wire
